deck_receiver: RTL and testbench

DECK_RECEIVER -- requirements
Module: deck_receiver

---
 rtl/deck_receiver_pkg.sv | 16 +
 rtl/deck_receiver_if.sv | 30 +++
 rtl/deck_receiver_card_buffer.sv | 29 ++
 rtl/deck_receiver.sv | 109 ++++++++++
 tb/tb_deck_receiver.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/deck_receiver_pkg.sv
// Shared blackjack definitions: deck geometry and the receiver state encoding.
package deck_receiver_pkg;

   localparam int BJ_DECK_SIZE = 52;
   localparam int BJ_CARD_W    = 6;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      REQ_SHUFFLE = 3'd1,
      LOADING     = 3'd2,
      READY       = 3'd3,
      EMPTY       = 3'd4,
      ERROR       = 3'd5
   } state_t;

endpackage

// File: rtl/deck_receiver_if.sv
// Shuffler and dealer signals of the deck receiver; master is the receiver side.
interface deck_receiver_if #(
   parameter int CARD_W = deck_receiver_pkg::BJ_CARD_W
);

   logic              start;
   logic              shuffle_flag;
   logic              load_flag;
   logic [CARD_W-1:0] card;
   logic              deal_req;
   logic              deal_valid;
   logic [CARD_W-1:0] deal_card;
   logic [CARD_W-1:0] cards_left;
   logic              deck_ready;
   logic              deck_empty;
   logic              load_error;

   modport master (
      input  start, load_flag, card, deal_req,
      output shuffle_flag, deal_valid, deal_card, cards_left,
             deck_ready, deck_empty, load_error
   );

   modport slave (
      output start, load_flag, card, deal_req,
      input  shuffle_flag, deal_valid, deal_card, cards_left,
             deck_ready, deck_empty, load_error
   );

endinterface

// File: rtl/deck_receiver_card_buffer.sv
// Card storage: one write port and one registered read port; array contents are not reset.
module card_buffer #(
   parameter int DEPTH  = 52,
   parameter int WIDTH  = 6,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register holds its value between reads so the dealt card stays stable.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/deck_receiver.sv
// Deck receiver: requests a shuffle, captures one card per 4 load cycles, then deals in order.
module deck_receiver
   import deck_receiver_pkg::*;
#(
   parameter int DECK_SIZE = BJ_DECK_SIZE,
   parameter int CARD_W    = BJ_CARD_W
) (
   input logic             clk,
   input logic             rst,
   deck_receiver_if.master bus
);

   localparam int                ADDR_W   = $clog2(DECK_SIZE);
   localparam logic [CARD_W-1:0] LAST_CAP = CARD_W'(DECK_SIZE - 1);
   localparam logic [CARD_W-1:0] ONE_LEFT = CARD_W'(1);
   localparam logic [CARD_W:0]   CARD_LIM = (CARD_W + 1)'(DECK_SIZE);

   state_t              state, state_nx;
   logic [1:0]          phase;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [DECK_SIZE-1:0] seen;
   logic [CARD_W-1:0]   cards_left_q;
   logic                deal_valid_q;
   logic                capture, card_ok, deal_fire, clear_deck;

   always_comb begin
      card_ok = 1'b0;
      if ({1'b0, bus.card} < CARD_LIM) card_ok = !seen[bus.card];
   end

   assign capture    = (state == LOADING) && bus.load_flag && (phase == 2'd3);
   assign deal_fire  = (state == READY) && bus.deal_req;
   assign clear_deck = bus.start && ((state == IDLE) || (state == EMPTY));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:        if (bus.start) state_nx = REQ_SHUFFLE;
         REQ_SHUFFLE: if (bus.load_flag) state_nx = LOADING;
         LOADING: begin
            if (capture) begin
               if (!card_ok)                      state_nx = ERROR;
               else if (cards_left_q == LAST_CAP) state_nx = READY;
            end
         end
         READY:       if (deal_fire && (cards_left_q == ONE_LEFT)) state_nx = EMPTY;
         EMPTY:       if (bus.start) state_nx = REQ_SHUFFLE;
         ERROR:       state_nx = ERROR;
         default:     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         phase        <= 2'd0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         seen         <= '0;
         cards_left_q <= '0;
         deal_valid_q <= 1'b0;
      end else begin
         state        <= state_nx;
         deal_valid_q <= deal_fire;
         if (clear_deck) begin
            phase        <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            seen         <= '0;
            cards_left_q <= '0;
         end
         // The edge that enters LOADING does not count as a load phase.
         if (state == REQ_SHUFFLE) phase <= 2'd0;
         if ((state == LOADING) && bus.load_flag) phase <= phase + 2'd1;
         if (capture && card_ok) begin
            seen[bus.card] <= 1'b1;
            wr_ptr         <= wr_ptr + ADDR_W'(1);
            cards_left_q   <= cards_left_q + CARD_W'(1);
         end
         if (deal_fire) begin
            rd_ptr       <= rd_ptr + ADDR_W'(1);
            cards_left_q <= cards_left_q - CARD_W'(1);
         end
      end
   end

   card_buffer #(
      .DEPTH  (DECK_SIZE),
      .WIDTH  (CARD_W),
      .ADDR_W (ADDR_W)
   ) u_buffer (
      .clk   (clk),
      .rst   (rst),
      .we    (capture && card_ok),
      .waddr (wr_ptr),
      .wdata (bus.card),
      .re    (deal_fire),
      .raddr (rd_ptr),
      .rdata (bus.deal_card)
   );

   assign bus.shuffle_flag = (state == REQ_SHUFFLE) || (state == LOADING);
   assign bus.deal_valid   = deal_valid_q;
   assign bus.cards_left   = cards_left_q;
   assign bus.deck_ready   = (state == READY);
   assign bus.deck_empty   = (state == EMPTY);
   assign bus.load_error   = (state == ERROR);

endmodule

// File: tb/tb_deck_receiver.sv
// Scoreboard bench for deck_receiver: shuffler model drives card sequences, a queue model predicts deals.
module tb_deck_receiver;
   import deck_receiver_pkg::*;

   localparam int DS = BJ_DECK_SIZE;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   deck_receiver_if bus ();

   deck_receiver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int total = 0;
   int bad   = 0;
   int exp_q [$];
   int m_deck [$];
   bit m_ready, m_empty, m_error;
   int sq [DS];
   bit got_rst;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Monitor: every deal_valid pulse must match the oldest predicted card.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.deal_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL deal_unexpected: got card %0d, expected no deal_valid", bus.deal_card);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(bus.deal_card) != e) begin
               bad++;
               $display("FAIL deal_card: got %0d expected %0d", bus.deal_card, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_deck.delete();
      m_ready = 1'b0;
      m_empty = 1'b0;
      m_error = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_shuffle_flag"}, int'(bus.shuffle_flag), 0);
      chk({tag, "_deal_valid"},   int'(bus.deal_valid),   0);
      chk({tag, "_deal_card"},    int'(bus.deal_card),    0);
      chk({tag, "_cards_left"},   int'(bus.cards_left),   0);
      chk({tag, "_deck_ready"},   int'(bus.deck_ready),   0);
      chk({tag, "_deck_empty"},   int'(bus.deck_empty),   0);
      chk({tag, "_load_error"},   int'(bus.load_error),   0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.load_flag = 1'b0;
      bus.deal_req = 1'b0;
      bus.card = '0;
      tick();
      tick();
      rst = 1'b0;
      clear_model();
      check_reset_vals(tag);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_deck_ready"},   int'(bus.deck_ready),   int'(m_ready));
      chk({tag, "_deck_empty"},   int'(bus.deck_empty),   int'(m_empty));
      chk({tag, "_load_error"},   int'(bus.load_error),   int'(m_error));
      chk({tag, "_cards_left"},   int'(bus.cards_left),   m_deck.size());
      chk({tag, "_shuffle_flag"}, int'(bus.shuffle_flag), 0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic shuffle_perm();
      for (int i = 0; i < DS; i++) sq[i] = i;
      for (int i = DS - 1; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = sq[i]; sq[i] = sq[j]; sq[j] = t;
      end
   endtask

   // Reference: accept codes in order until one is out of range or repeated.
   task automatic model_load();
      bit used [64];
      m_deck.delete();
      m_error = 1'b0;
      m_empty = 1'b0;
      for (int i = 0; i < 64; i++) used[i] = 1'b0;
      for (int i = 0; i < DS; i++) begin
         if (sq[i] >= DS || used[sq[i]]) begin
            m_error = 1'b1;
            break;
         end
         used[sq[i]] = 1'b1;
         m_deck.push_back(sq[i]);
      end
      m_ready = !m_error;
   endtask

   // Shuffler model: card k is held for load-active edges 4k+1..4k+4 (card 0 also on edge 0).
   task automatic run_shuffler(input int gap_e, input int rst_e, output bit rst_hit);
      int  e, cyc, idx, gap_left;
      bit  gap_done;
      e = 0; cyc = 0; gap_left = 0; gap_done = 1'b0; rst_hit = 1'b0;
      chk("shuffle_flag_request", int'(bus.shuffle_flag), 1);
      if (bus.shuffle_flag !== 1'b1) return;
      while (cyc < 400 && bus.shuffle_flag === 1'b1) begin
         if (gap_e >= 0 && e == gap_e && !gap_done) begin
            gap_left = 3;
            gap_done = 1'b1;
         end
         if (gap_left > 0) begin
            bus.load_flag = 1'b0;
            gap_left--;
         end else begin
            bus.load_flag = 1'b1;
         end
         idx = (e == 0) ? 0 : (e - 1) / 4;
         if (idx > DS - 1) idx = DS - 1;
         bus.card = 6'(sq[idx]);
         if (rst_e >= 0 && e == rst_e && bus.load_flag) begin
            chk("cards_left_before_rst", int'(bus.cards_left), 29);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            bus.load_flag = 1'b0;
            clear_model();
            check_reset_vals("rst_mid_load");
            rst_hit = 1'b1;
            return;
         end
         tick();
         cyc++;
         if (bus.load_flag) e++;
      end
      bus.load_flag = 1'b0;
      chk("shuffle_flag_drop", int'(bus.shuffle_flag), 0);
   endtask

   task automatic deal(input int ncyc, input bit rnd, input bit chk_cnt);
      for (int i = 0; i < ncyc; i++) begin
         bus.deal_req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.deal_req && m_ready && m_deck.size() > 0) begin
            exp_q.push_back(m_deck.pop_front());
            if (m_deck.size() == 0) begin
               m_ready = 1'b0;
               m_empty = 1'b1;
            end
         end
         tick();
         if (chk_cnt) chk("cards_left_deal", int'(bus.cards_left), m_deck.size());
      end
      bus.deal_req = 1'b0;
      tick();
      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_model();
      do_reset("reset");
      deal(3, 1'b0, 1'b1);

      // Ordered deck 0..51, full deal with deal_req held.
      for (int i = 0; i < DS; i++) sq[i] = i;
      model_load();
      pulse_start();
      run_shuffler(-1, -1, got_rst);
      check_status("ordered_load");
      pulse_start();
      check_status("start_in_ready");
      deal(DS, 1'b0, 1'b1);
      check_status("ordered_dealt");

      // Restart from EMPTY, load_flag gap mid-card, random deal requests.
      shuffle_perm();
      model_load();
      pulse_start();
      run_shuffler(4 * 20 + 2, -1, got_rst);
      check_status("gap_load");
      deal(300, 1'b1, 1'b1);
      check_status("gap_dealt");

      // Code 17 repeated as the 10th card.
      shuffle_perm();
      for (int i = 0; i < DS; i++) begin
         if (sq[i] == 17) begin
            sq[i] = sq[3];
            sq[3] = 17;
         end
      end
      sq[9] = 17;
      model_load();
      pulse_start();
      run_shuffler(-1, -1, got_rst);
      check_status("dup_error");
      deal(5, 1'b0, 1'b1);
      pulse_start();
      check_status("dup_sticky");

      // Out-of-range code 55.
      do_reset("reset_b");
      shuffle_perm();
      sq[$urandom_range(0, DS - 1)] = 55;
      model_load();
      pulse_start();
      run_shuffler(-1, -1, got_rst);
      check_status("range_error");

      // Reset at the 30th capture, then a full reload and deal.
      do_reset("reset_c");
      shuffle_perm();
      model_load();
      pulse_start();
      run_shuffler(4 * 30, -1 + 4 * 30 + 1 - 1, got_rst);
      chk("rst_mid_load_hit", int'(got_rst), 1);
      shuffle_perm();
      model_load();
      pulse_start();
      run_shuffler(-1, -1, got_rst);
      check_status("reload");
      deal(60, 1'b0, 1'b1);
      check_status("reload_dealt");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
